// File: rtl/io_port_arbiter_pkg.sv
// Shared definitions for the port-B I/O arbiter: FSM states, requester
// indices and the modulo-3 helper used by the round-robin picker.
package io_port_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  // Wait counter holds READ_LATENCY-1, READ_LATENCY in 1..4
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_VGA = 2'd0,
    REQ_KBD = 2'd1,
    REQ_DBG = 2'd2
  } req_idx_e;

  // (base + step) mod 3 for base, step in 0..2
  function automatic logic [1:0] wrap_add3(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/io_port_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//   req     in  3  request vector, bit index = requester index
//   start   in  2  first index searched (one past the previous winner)
//   urgent  in  1  index 0 wins outright when it is also requesting
//   valid   out 1  any request present
//   winner  out 2  selected index (meaningful only when valid)
module rr_pick3
  import io_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  input  logic       urgent,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] cand;

  // Scan farthest-first so the nearest requester to start is written last
  always_comb begin
    valid  = |req;
    winner = REQ_VGA;
    cand   = start;
    if (urgent && req[REQ_VGA]) begin
      winner = REQ_VGA;
    end else begin
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        cand = wrap_add3(start, 2'(k));
        if (req[cand]) winner = cand;
      end
    end
  end

endmodule

// File: rtl/io_port_arbiter.sv
// io_port_arbiter: shares RAM port B between VGA (read), keyboard (write)
// and debug (read/write) with round-robin fairness and a VGA urgent override.
// One transaction outstanding at a time.
//   clk, rst                 clock, async active-low reset
//   vga_req/urgent/addr      VGA read request; vga_gnt, vga_rvalid, vga_rdata back
//   kbd_req/addr/wdata       keyboard write request; kbd_gnt back
//   dbg_req/we/addr/wdata    debug request; dbg_gnt, dbg_rvalid, dbg_rdata back
//   io_addr/io_wren/io_wdata registered RAM port-B controls; io_rdata = RAM q_b
//   busy                     FSM not idle
module io_port_arbiter
  import io_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic              vga_urgent,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              kbd_req,
  input  logic [ADDR_W-1:0] kbd_addr,
  input  logic [DATA_W-1:0] kbd_wdata,
  output logic              kbd_gnt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_wren,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              busy
);

  arb_state_e        state, state_nxt;
  req_idx_e          owner, owner_nxt;
  logic              we_q, we_nxt;
  logic [1:0]        rr_start, rr_start_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] io_addr_nxt;
  logic [DATA_W-1:0] io_wdata_nxt;
  logic              io_wren_nxt;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic              rd_done;
  logic [DATA_W-1:0] vga_rdata_q, dbg_rdata_q;

  rr_pick3 u_pick (
    .req    ({dbg_req, kbd_req, vga_req}),
    .start  (rr_start),
    .urgent (vga_urgent),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // State and port-B register bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      owner       <= REQ_VGA;
      we_q        <= 1'b0;
      rr_start    <= REQ_VGA;
      cnt         <= '0;
      io_addr     <= '0;
      io_wdata    <= '0;
      io_wren     <= 1'b0;
      vga_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      we_q     <= we_nxt;
      rr_start <= rr_start_nxt;
      cnt      <= cnt_nxt;
      io_addr  <= io_addr_nxt;
      io_wdata <= io_wdata_nxt;
      io_wren  <= io_wren_nxt;
      if (vga_rvalid) vga_rdata_q <= io_rdata;
      if (dbg_rvalid) dbg_rdata_q <= io_rdata;
    end
  end

  // Next-state: arbitrate only in IDLE; port-B values are loaded on the
  // IDLE->ISSUE edge so they are already registered during ISSUE.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    we_nxt       = we_q;
    rr_start_nxt = rr_start;
    cnt_nxt      = cnt;
    io_addr_nxt  = io_addr;
    io_wdata_nxt = io_wdata;
    io_wren_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt    = ST_ISSUE;
          owner_nxt    = req_idx_e'(pick_idx);
          rr_start_nxt = wrap_add3(pick_idx, 2'd1);
          unique case (req_idx_e'(pick_idx))
            REQ_VGA: begin
              we_nxt      = 1'b0;
              io_addr_nxt = vga_addr;
            end
            REQ_KBD: begin
              we_nxt       = 1'b1;
              io_addr_nxt  = kbd_addr;
              io_wdata_nxt = kbd_wdata;
            end
            default: begin
              we_nxt      = dbg_we;
              io_addr_nxt = dbg_addr;
              if (dbg_we) io_wdata_nxt = dbg_wdata;
            end
          endcase
          io_wren_nxt = we_nxt;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(READ_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grants and completions are decodes of registered state
  assign rd_done    = (state == ST_WAIT) && (cnt == '0);
  assign vga_gnt    = (state == ST_ISSUE) && (owner == REQ_VGA);
  assign kbd_gnt    = (state == ST_ISSUE) && (owner == REQ_KBD);
  assign dbg_gnt    = (state == ST_ISSUE) && (owner == REQ_DBG);
  assign vga_rvalid = rd_done && (owner == REQ_VGA);
  assign dbg_rvalid = rd_done && (owner == REQ_DBG);
  assign busy       = (state != ST_IDLE);

  // Read data is live from the RAM in the completion cycle, then held
  assign vga_rdata = vga_rvalid ? io_rdata : vga_rdata_q;
  assign dbg_rdata = dbg_rvalid ? io_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed self-checking bench for io_port_arbiter with a READ_LATENCY=2
// RAM model (address register + output register).
module tb_io_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RL     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_req, vga_urgent;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt, vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              kbd_req;
  logic [ADDR_W-1:0] kbd_addr;
  logic [DATA_W-1:0] kbd_wdata;
  logic              kbd_gnt;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] io_addr;
  logic              io_wren;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  io_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_urgent(vga_urgent), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .kbd_req(kbd_req), .kbd_addr(kbd_addr), .kbd_wdata(kbd_wdata), .kbd_gnt(kbd_gnt),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .io_addr(io_addr), .io_wren(io_wren), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM port B model: address register then output register
  logic [DATA_W-1:0] mem [0:255];
  logic [7:0]        ram_a;
  logic [DATA_W-1:0] ram_q;
  logic              ld_en = 1'b0;
  logic [7:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en)        mem[ld_addr] <= ld_data;
    else if (io_wren) mem[io_addr[7:0]] <= io_wdata;
    ram_a <= io_addr[7:0];
    ram_q <= mem[ram_a];
  end
  assign io_rdata = ram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Next negedge with any grant, bounded; g stays 0 on timeout
  task automatic get_grant(output logic [2:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g = {dbg_gnt, kbd_gnt, vga_gnt};
      if (g != 3'b000) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_vga_rvalid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vga_rvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g, g1, g2;
    logic [2:0] exp4 [6];
    logic       stray;
    exp4 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // 1: reset with every request asserted
    rst = 1'b0;
    vga_req = 1'b1; vga_urgent = 1'b0; vga_addr = 32'h10;
    kbd_req = 1'b1; kbd_addr = 32'h30; kbd_wdata = 32'h55;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wdata = 32'h0;
    preload(8'h10, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("rst io_addr",  64'(io_addr), 64'h0);
    chk("rst io_wren",  64'(io_wren), 64'h0);
    chk("rst io_wdata", 64'(io_wdata), 64'h0);
    chk("rst gnts",     64'({dbg_gnt, kbd_gnt, vga_gnt}), 64'h0);
    chk("rst rvalids",  64'({dbg_rvalid, vga_rvalid}), 64'h0);
    chk("rst vga_rdata", 64'(vga_rdata), 64'h0);
    chk("rst dbg_rdata", 64'(dbg_rdata), 64'h0);
    chk("rst busy",     64'(busy), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("first grant vga", 64'({dbg_gnt, kbd_gnt, vga_gnt}), 64'b001);
    vga_req = 1'b0; kbd_req = 1'b0; dbg_req = 1'b0;
    wait_idle("t1 idle");

    // 2: VGA read of 0x10, cycle-exact latency
    vga_req = 1'b1; vga_addr = 32'h10;
    @(negedge clk);
    chk("t2 vga_gnt T+1", 64'(vga_gnt), 64'd1);
    chk("t2 io_addr",     64'(io_addr), 64'h10);
    chk("t2 io_wren",     64'(io_wren), 64'd0);
    chk("t2 busy",        64'(busy), 64'd1);
    vga_req = 1'b0;
    @(negedge clk);
    chk("t2 no rvalid T+2", 64'(vga_rvalid), 64'd0);
    @(negedge clk);
    chk("t2 vga_rvalid T+3", 64'(vga_rvalid), 64'd1);
    chk("t2 vga_rdata",      64'(vga_rdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("t2 rvalid pulse",   64'(vga_rvalid), 64'd0);
    chk("t2 rdata held",     64'(vga_rdata), 64'hDEADBEEF);
    chk("t2 idle",           64'(busy), 64'd0);

    // 3: keyboard write then debug read-back
    kbd_req = 1'b1; kbd_addr = 32'h20; kbd_wdata = 32'h41;
    @(negedge clk);
    chk("t3 kbd_gnt",  64'(kbd_gnt), 64'd1);
    chk("t3 io_wren",  64'(io_wren), 64'd1);
    chk("t3 io_addr",  64'(io_addr), 64'h20);
    chk("t3 io_wdata", 64'(io_wdata), 64'h41);
    kbd_req = 1'b0;
    @(negedge clk);
    chk("t3 wren one cycle", 64'(io_wren), 64'd0);
    chk("t3 addr held",      64'(io_addr), 64'h20);
    chk("t3 write done",     64'(busy), 64'd0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    @(negedge clk);
    chk("t3 dbg_gnt", 64'(dbg_gnt), 64'd1);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3 dbg_rvalid", 64'(dbg_rvalid), 64'd1);
    chk("t3 dbg_rdata",  64'(dbg_rdata), 64'h41);
    wait_idle("t3 idle");

    // 4: all three requesting continuously -> strict rotation
    vga_req = 1'b1; vga_addr = 32'h10;
    kbd_req = 1'b1; kbd_addr = 32'h30; kbd_wdata = 32'h55;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      get_grant(g);
      chk($sformatf("t4 grant %0d", i), 64'(g), 64'(exp4[i]));
    end
    vga_req = 1'b0; kbd_req = 1'b0; dbg_req = 1'b0;
    wait_idle("t4 idle");
    chk("t4 vga_rdata", 64'(vga_rdata), 64'hDEADBEEF);
    chk("t4 dbg_rdata", 64'(dbg_rdata), 64'h41);

    // 5: KBD was last winner (DBG next by rotation); urgent VGA overrides
    kbd_req = 1'b1; kbd_addr = 32'h30; kbd_wdata = 32'h66;
    get_grant(g);
    chk("t5 setup kbd", 64'(g), 64'b010);
    kbd_req = 1'b0;
    wait_idle("t5 setup idle");
    vga_req = 1'b1; vga_urgent = 1'b1; vga_addr = 32'h10;
    kbd_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    get_grant(g);
    chk("t5 urgent vga", 64'(g), 64'b001);
    vga_req = 1'b0; vga_urgent = 1'b0;
    get_grant(g1);
    if (g1[1]) kbd_req = 1'b0;
    if (g1[2]) dbg_req = 1'b0;
    get_grant(g2);
    kbd_req = 1'b0; dbg_req = 1'b0;
    chk("t5 both served", 64'(g1 | g2), 64'b110);
    chk("t5 distinct",    64'(g1 ^ g2), 64'b110);
    wait_idle("t5 idle");

    // 6: reset while a debug read is in WAIT
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    get_grant(g);
    chk("t6 dbg grant", 64'(g), 64'b100);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("t6 in wait", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6 busy in rst",   64'(busy), 64'd0);
    chk("t6 rvalid in rst", 64'(dbg_rvalid), 64'd0);
    stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (dbg_rvalid) stray = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dbg_rvalid || busy) stray = 1'b1;
    end
    chk("t6 no stray rvalid", 64'(stray), 64'd0);
    chk("t6 dbg_rdata clear", 64'(dbg_rdata), 64'h0);
    vga_req = 1'b1; vga_addr = 32'h20;
    get_grant(g);
    chk("t6 new grant vga", 64'(g), 64'b001);
    vga_req = 1'b0;
    wait_vga_rvalid("t6 vga rvalid");
    chk("t6 vga_rdata", 64'(vga_rdata), 64'h41);
    wait_idle("t6 idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
